single_cycle_mips: RTL and testbench

- Single-cycle 32-bit MIPS subset processor: fetch, decode, execute, memory access and writeback all complete in one clock.
- Contains its own instruction memory, 32x32 register file and data memory.
- Top-level CPU block for simulation.
- Benches preload instructions and dump state hierarchically, so instance/array names below are mandatory.

---
 rtl/mips_pkg.sv | 100 ++++++++++
 rtl/single_cycle_mips_alu.sv | 29 ++
 rtl/single_cycle_mips_storage.sv | 66 ++++++
 rtl/single_cycle_mips.sv | 126 ++++++++++++
 tb/tb_single_cycle_mips.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: opcodes, functs, ALU ops, control word.
// Pure declarations; no latency. No flow control.
// decode() maps opcode/funct to the control word; unknown encodings decode to a no-write nop.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    jal;
        logic    jr;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    FN_SLL:  c.alu_op = ALU_SLL;
                    FN_SRL:  c.alu_op = ALU_SRL;
                    FN_JR: begin
                        c.reg_write = 1'b0;
                        c.jr        = 1'b1;
                    end
                    default: c.reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_ADD; end
            OP_SLTI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_SLT; end
            OP_ANDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_AND; end
            OP_ORI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OR;  end
            OP_LW: begin
                c.alu_src    = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_BEQ: begin c.branch = 1'b1; c.alu_op = ALU_SUB; end
            OP_BNE: begin c.branch = 1'b1; c.branch_ne = 1'b1; c.alu_op = ALU_SUB; end
            OP_J:   c.jump = 1'b1;
            OP_JAL: begin
                c.jump      = 1'b1;
                c.jal       = 1'b1;
                c.reg_write = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/single_cycle_mips_alu.sv
// Combinational 32-bit ALU for the MIPS core (add/sub/and/or/slt/sll/srl).
// Latency: zero cycles. No flow control.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            default: result = '0;
        endcase
        zero = (result == 32'h0);
    end

endmodule

// File: rtl/single_cycle_mips_storage.sv
// Storage blocks of the core: instruction ROM, 32x32 register file, data RAM.
// Reads are combinational; writes land on the rising clock edge. No flow control.
module mips_imem #(
    parameter int WORDS = 256
) (
    input  logic [29:0] word_idx,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Filled from outside the core; the core never writes it.
    logic [31:0] memory [0:WORDS-1];

    always_comb begin
        rdata = 32'h0;
        if (word_idx < 30'(WORDS)) rdata = memory[word_idx[AW-1:0]];
    end
endmodule

module mips_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) registers[i] <= 32'h0;
        end else if (we && (wa != 5'd0)) begin
            registers[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : registers[ra2];
endmodule

module mips_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clock,
    input  logic        we,
    input  logic [29:0] word_idx,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [31:0] memory [0:WORDS-1];
    logic        in_range;

    assign in_range = (word_idx < 30'(WORDS));

    always_ff @(posedge clock) begin
        if (we && in_range) memory[word_idx[AW-1:0]] <= wdata;
    end

    assign rdata = in_range ? memory[word_idx[AW-1:0]] : 32'h0;
endmodule

// File: rtl/single_cycle_mips.sv
// Single-cycle MIPS subset CPU: fetch..writeback in one clock; optional MIPS_TRACE_EN prints a per-edge trace.
// Latency: one instruction per clock. No flow control; synchronous active-high reset.
module single_cycle_mips
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    ctrl_t       ctrl;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] imm_ext, sext_imm;
    logic [31:0] rs_val, rt_val;
    logic [31:0] alu_b, alu_result;
    logic        alu_zero;
    logic [31:0] dmem_rdata;
    logic [31:0] jump_target, branch_target;
    logic        branch_taken;
    logic        reg_we, mem_we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    assign pc_out   = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    mips_imem #(.WORDS(IMEM_WORDS)) inst_mem (
        .word_idx (pc_q[31:2]),
        .rdata    (instr)
    );

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm16  = instr[15:0];
    assign ctrl   = decode(opcode, funct);

    // andi/ori take a zero-extended immediate; every other immediate user is signed.
    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign imm_ext  = ((opcode == OP_ANDI) || (opcode == OP_ORI)) ? {16'h0, imm16} : sext_imm;

    mips_regfile regs (
        .clock (clock),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (reg_we),
        .wa    (wr_addr),
        .wd    (wr_data)
    );

    assign alu_b = ctrl.alu_src ? imm_ext : rt_val;

    mips_alu alu (
        .a      (rs_val),
        .b      (alu_b),
        .shamt  (shamt),
        .op     (ctrl.alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign mem_we = ctrl.mem_write && !reset;

    mips_dmem #(.WORDS(DMEM_WORDS)) data_mem (
        .clock    (clock),
        .we       (mem_we),
        .word_idx (alu_result[31:2]),
        .wdata    (rt_val),
        .rdata    (dmem_rdata)
    );

    always_comb begin
        wr_addr = ctrl.reg_dst ? rd : rt;
        wr_data = ctrl.mem_to_reg ? dmem_rdata : alu_result;
        if (ctrl.jal) begin
            wr_addr = 5'd31;
            wr_data = pc_plus4;
        end
        reg_we = ctrl.reg_write && !reset;
    end

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign branch_taken  = ctrl.branch && (ctrl.branch_ne ? !alu_zero : alu_zero);

    always_comb begin
        pc_d = pc_plus4;
        if (ctrl.jr)            pc_d = rs_val;
        else if (ctrl.jump)     pc_d = jump_target;
        else if (branch_taken)  pc_d = branch_target;
    end

    always_ff @(posedge clock) begin
        if (reset) pc_q <= 32'h0;
        else       pc_q <= pc_d;
    end

`ifdef MIPS_TRACE_EN
    always @(posedge clock) begin
        if (!reset) begin
            if (reg_we && (wr_addr != 5'd0))
                $display("%0t pc=%08h instr=%08h r%0d<=%08h", $time, pc_q, instr, wr_addr, wr_data);
            else if (mem_we)
                $display("%0t pc=%08h instr=%08h mem[%08h]<=%08h", $time, pc_q, instr, alu_result, rt_val);
            else
                $display("%0t pc=%08h instr=%08h", $time, pc_q, instr);
        end
    end
`endif

endmodule

// File: tb/tb_single_cycle_mips.sv
// Scoreboard bench: expected pc/register/memory values are queued per cycle and checked by a monitor.
module tb_single_cycle_mips;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_out;

    single_cycle_mips #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clock  (clock),
        .reset  (reset),
        .pc_out (pc_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        int          kind;   // 0 pc, 1 register, 2 data word
        int          idx;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cycle  = 0;
    bit   mon_en = 1'b0;

    task automatic expect_at(input int cyc, input int kind, input int idx,
                             input logic [31:0] val, input string nm);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic expect_regs_zero(input int cyc);
        for (int r = 0; r < 32; r++) expect_at(cyc, 1, r, 32'h0, $sformatf("reg%0d_zero", r));
    endtask

    // Monitor: cycle k = state after k executing edges since reset release.
    always @(negedge clock) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc <= cycle) begin
                exp_t        e;
                logic [31:0] act;
                logic [4:0]  ridx;
                logic [7:0]  midx;
                e    = sb.pop_front();
                ridx = e.idx[4:0];
                midx = e.idx[7:0];
                case (e.kind)
                    0:       act = pc_out;
                    1:       act = dut.regs.registers[ridx];
                    default: act = dut.data_mem.memory[midx];
                endcase
                tests++;
                if (act !== e.val) begin
                    fails++;
                    $display("FAIL %s cyc=%0d: got %08h expected %08h", e.nm, cycle, act, e.val);
                end
            end
            cycle++;
        end
    end

    logic [31:0] pcs [0:17];

    initial begin
        for (int i = 0; i < 256; i++) dut.inst_mem.memory[i] = 32'h0;
        dut.inst_mem.memory[0]  = 32'h20010005; // addi $1,$0,5
        dut.inst_mem.memory[1]  = 32'h2002FFFD; // addi $2,$0,-3
        dut.inst_mem.memory[2]  = 32'h00221820; // add  $3,$1,$2
        dut.inst_mem.memory[3]  = 32'hAC010008; // sw   $1,8($0)
        dut.inst_mem.memory[4]  = 32'h10210002; // beq  $1,$1,+2
        dut.inst_mem.memory[5]  = 32'h20070001; // addi $7,$0,1 (skipped)
        dut.inst_mem.memory[6]  = 32'h20070002; // addi $7,$0,2 (skipped)
        dut.inst_mem.memory[7]  = 32'h8C040008; // lw   $4,8($0)
        dut.inst_mem.memory[8]  = 32'h0C000040; // jal  0x40
        dut.inst_mem.memory[9]  = 32'h14210002; // bne  $1,$1,+2
        dut.inst_mem.memory[10] = 32'h20000007; // addi $0,$0,7
        dut.inst_mem.memory[11] = 32'h0041282A; // slt  $5,$2,$1
        dut.inst_mem.memory[12] = 32'h00013100; // sll  $6,$1,4
        dut.inst_mem.memory[13] = 32'hFC21FFFF; // unknown opcode 0x3F
        dut.inst_mem.memory[14] = 32'h00224022; // sub  $8,$1,$2
        dut.inst_mem.memory[15] = 32'h00224825; // or   $9,$1,$2
        dut.inst_mem.memory[16] = 32'hAC020008; // sw   $2,8($0) under reset
        dut.inst_mem.memory[64] = 32'h03E00008; // jr   $31

        pcs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h100,
                32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40,
                32'h00, 32'h04};

        // Expectations, in cycle order.
        expect_regs_zero(0);
        for (int k = 0; k < 18; k++) begin
            expect_at(k, 0, 0, pcs[k], $sformatf("pc_k%0d", k));
            case (k)
                3: begin
                    expect_at(k, 1, 1, 32'h5,        "addi_r1");
                    expect_at(k, 1, 2, 32'hFFFFFFFD, "addi_r2_neg");
                    expect_at(k, 1, 3, 32'h2,        "add_r3");
                end
                4:  expect_at(k, 2, 2, 32'h5,        "sw_mem2");
                5:  expect_at(k, 1, 7, 32'h0,        "beq_skip_r7");
                6:  expect_at(k, 1, 4, 32'h5,        "lw_r4");
                7:  expect_at(k, 1, 31, 32'h24,      "jal_r31");
                10: expect_at(k, 1, 0, 32'h0,        "r0_stays_zero");
                11: expect_at(k, 1, 5, 32'h1,        "slt_r5");
                12: expect_at(k, 1, 6, 32'd80,       "sll_r6");
                13: begin
                    expect_at(k, 1, 1, 32'h5,        "unknown_op_r1");
                    expect_at(k, 2, 2, 32'h5,        "unknown_op_mem2");
                end
                14: expect_at(k, 1, 8, 32'h8,        "sub_r8");
                15: expect_at(k, 1, 9, 32'hFFFFFFFD, "or_r9");
                16: begin
                    expect_regs_zero(k);
                    expect_at(k, 2, 2, 32'h5,        "reset_keeps_mem2");
                end
                17: expect_at(k, 1, 1, 32'h5,        "rerun_r1");
                default: ;
            endcase
        end

        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        mon_en = 1'b1;
        repeat (15) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;

        for (int t = 0; t < 100 && sb.size() > 0; t++) @(posedge clock);
        @(negedge clock);
        #1;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
